// File: rtl/ppm_pkg.sv
// Shared constants and helpers for the 4-PPM transmit path.
// The state encoding is one-hot, matching the encoder.
package ppm_pkg;

    localparam int PPM_SYM_CYCLES    = 128;
    localparam int PPM_SYMS_PER_BYTE = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_LAUNCH = 3'b010,
        ST_BUSY   = 3'b100
    } ppm_state_e;

    // Advance the symbol shift register by one 2-bit symbol; vacated bits fill with 0.
    function automatic logic [7:0] ppm_shift2(input logic [7:0] sr, input logic msb_first);
        return msb_first ? {sr[5:0], 2'b00} : {2'b00, sr[7:2]};
    endfunction

endpackage

// File: rtl/ppm_symbolizer.sv
// Splits bytes into four 2-bit PPM symbols for the 4-PPM encoder.
// The block paces itself on the encoder's ppm_done and can prepend a preamble per burst.
module ppm_symbolizer
    import ppm_pkg::*;
#(
    parameter bit         MSB_FIRST   = 1'b1,
    parameter bit         PREAMBLE_EN = 1'b0,
    parameter logic [7:0] PREAMBLE    = 8'hE4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [1:0] ppm_code,
    output logic       ppm_strobe,
    input  logic       ppm_done,
    output logic       busy
);

    ppm_state_e state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] sym_left_q, sym_left_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_vld_q, buf_vld_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sr_q       <= 8'h00;
            sym_left_q <= 3'd0;
            buf_q      <= 8'h00;
            buf_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            sym_left_q <= sym_left_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        sym_left_d = sym_left_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;

        unique case (state_q)
            ST_IDLE: begin
                if (buf_vld_q) begin
                    // With a preamble the data byte stays buffered until the preamble drains.
                    if (PREAMBLE_EN) begin
                        sr_d = PREAMBLE;
                    end else begin
                        sr_d      = buf_q;
                        buf_vld_d = 1'b0;
                    end
                    sym_left_d = 3'(PPM_SYMS_PER_BYTE);
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (ppm_done) begin
                    if (sym_left_q > 3'd1) begin
                        sr_d       = ppm_shift2(sr_q, MSB_FIRST);
                        sym_left_d = sym_left_q - 3'd1;
                    end else if (buf_vld_q) begin
                        sr_d       = buf_q;
                        buf_vld_d  = 1'b0;
                        sym_left_d = 3'(PPM_SYMS_PER_BYTE);
                    end else begin
                        sym_left_d = 3'd0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept only into an empty buffer, so this never collides with a buffer drain above.
        if (s_valid && !buf_vld_q) begin
            buf_d     = s_data;
            buf_vld_d = 1'b1;
        end
    end

    always_comb begin
        s_ready    = !buf_vld_q;
        ppm_code   = MSB_FIRST ? sr_q[7:6] : sr_q[1:0];
        ppm_strobe = (state_q == ST_LAUNCH) ||
                     ((state_q == ST_BUSY) && ((sym_left_q > 3'd1) || buf_vld_q));
        busy       = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_ppm_symbolizer.sv
// Directed bench: three symbolizer configurations, each driving a behavioural 4-PPM encoder.
// Instance 0: MSB first, no preamble; 1: LSB first; 2: MSB first with preamble 8'hE4.
`timescale 1ns/1ps
module tb_ppm_symbolizer;

    localparam logic [2:0] MSB_CFG = 3'b101;
    localparam logic [2:0] PRE_CFG = 3'b100;
    localparam longint     SYM_NS  = 1280;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data [3];
    logic       s_valid [3];
    logic       s_ready [3];
    logic [1:0] ppm_code [3];
    logic       ppm_strobe [3];
    logic       ppm_done [3];
    logic       busy [3];

    int tests = 0;
    int fails = 0;

    logic [1:0] code_q [$];
    logic       strb_q [$];
    longint     time_q [$];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            logic       run_q;
            logic [6:0] cnt_q;
            logic [1:0] prev_code;
            int         glitch_cnt = 0;

            ppm_symbolizer #(
                .MSB_FIRST  (MSB_CFG[gi]),
                .PREAMBLE_EN(PRE_CFG[gi]),
                .PREAMBLE   (8'hE4)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .s_data    (s_data[gi]),
                .s_valid   (s_valid[gi]),
                .s_ready   (s_ready[gi]),
                .ppm_code  (ppm_code[gi]),
                .ppm_strobe(ppm_strobe[gi]),
                .ppm_done  (ppm_done[gi]),
                .busy      (busy[gi])
            );

            // Encoder model: strobe starts a symbol, strobe in the count-127 cycle continues.
            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    run_q <= 1'b0;
                    cnt_q <= 7'd0;
                end else if (!run_q) begin
                    if (ppm_strobe[gi]) begin
                        run_q <= 1'b1;
                        cnt_q <= 7'd0;
                    end
                end else if (cnt_q == 7'd127) begin
                    if (ppm_strobe[gi]) cnt_q <= 7'd0;
                    else                run_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 7'd1;
                end
            end
            assign ppm_done[gi] = run_q && (cnt_q == 7'd127);

            // The symbol must not change inside a symbol period.
            always @(negedge clk) begin
                if (run_q && cnt_q != 7'd0 && ppm_code[gi] !== prev_code) glitch_cnt++;
                prev_code = ppm_code[gi];
            end
        end
    endgenerate

    // Pre-edge values of every ppm_done cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ppm_done[i] && rst_n) begin
                code_q.push_back(ppm_code[i]);
                strb_q.push_back(ppm_strobe[i]);
                time_q.push_back($time);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        code_q.delete();
        strb_q.delete();
        time_q.delete();
    endtask

    task automatic send(input int i, input logic [7:0] b);
        bit done;
        done = 1'b0;
        @(negedge clk);
        s_data[i]  = b;
        s_valid[i] = 1'b1;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (s_ready[i]) begin
                @(posedge clk);
                #1;
                s_valid[i] = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            s_valid[i] = 1'b0;
            check("send_timeout", 32'd0, 32'd1);
        end
    endtask

    // Waits for n symbol ends, then checks count, symbol order, strobes, spacing and idle.
    task automatic expect_syms(input int i, input string tag, input int n,
                               input logic [31:0] exp_codes, input logic [15:0] exp_strb);
        logic [31:0] codes;
        logic [15:0] strb;
        int          gaps;
        for (int c = 0; c < n * 600 + 50 && code_q.size() < n; c++) @(negedge clk);
        check({tag, "_count"}, 32'(code_q.size()), 32'(n));
        check({tag, "_busy_end"}, 32'(busy[i]), 32'd0);
        codes = '0;
        strb  = '0;
        gaps  = 0;
        foreach (code_q[j]) begin
            codes = {codes[29:0], code_q[j]};
            strb  = {strb[14:0], strb_q[j]};
            if (j > 0 && (time_q[j] - time_q[j-1]) != SYM_NS) gaps++;
        end
        check({tag, "_codes"}, codes, exp_codes);
        check({tag, "_strobes"}, 32'(strb), 32'(exp_strb));
        check({tag, "_gaps"}, 32'(gaps), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            s_data[i]  = 8'h00;
            s_valid[i] = 1'b0;
        end

        // Reset state
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready%0d", i), 32'(s_ready[i]), 32'd1);
            check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("rst_strobe%0d", i), 32'(ppm_strobe[i]), 32'd0);
            check($sformatf("rst_code%0d", i), 32'(ppm_code[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte, MSB first, with latency checks
        clear_q();
        send(0, 8'h1B);
        @(negedge clk);
        check("t1_busy_k", 32'(busy[0]), 32'd0);
        check("t1_strobe_k", 32'(ppm_strobe[0]), 32'd0);
        @(negedge clk);
        check("t1_busy_k1", 32'(busy[0]), 32'd1);
        check("t1_strobe_k1", 32'(ppm_strobe[0]), 32'd1);
        check("t1_code_k1", 32'(ppm_code[0]), 32'd0);
        expect_syms(0, "t1", 4, 32'h1B, 16'b1110);
        $display("[TB] t1 byte 1B msb-first: %0d symbols", code_q.size());

        // 2: back-to-back FF then 00
        clear_q();
        send(0, 8'hFF);
        @(negedge clk);
        check("t2_ready_full", 32'(s_ready[0]), 32'd0);
        send(0, 8'h00);
        expect_syms(0, "t2", 8, 32'hFF00, 16'hFE);
        $display("[TB] t2 bytes FF,00: %0d symbols", code_q.size());

        // 3: LSB first
        clear_q();
        send(1, 8'h1B);
        expect_syms(1, "t3", 4, 32'hE4, 16'b1110);
        $display("[TB] t3 byte 1B lsb-first: %0d symbols", code_q.size());

        // 4: preamble, then a second burst gets the preamble again
        clear_q();
        send(2, 8'h55);
        expect_syms(2, "t4a", 8, 32'hE455, 16'hFE);
        $display("[TB] t4a preamble+55: %0d symbols", code_q.size());
        clear_q();
        send(2, 8'hC3);
        expect_syms(2, "t4b", 8, 32'hE4C3, 16'hFE);
        $display("[TB] t4b preamble+C3: %0d symbols", code_q.size());

        // 5: s_valid held high across four bytes under backpressure
        clear_q();
        begin
            logic [31:0] bytes;
            bit          ok;
            bytes = 32'h12345678;
            @(negedge clk);
            s_valid[0] = 1'b1;
            for (int j = 0; j < 4; j++) begin
                s_data[0] = bytes[31 - 8*j -: 8];
                ok = 1'b0;
                for (int c = 0; c < 2000 && !ok; c++) begin
                    if (s_ready[0]) begin
                        @(posedge clk);
                        #1;
                        ok = 1'b1;
                    end else begin
                        @(negedge clk);
                    end
                end
                if (!ok) check("t5_accept_timeout", 32'd0, 32'd1);
                @(negedge clk);
            end
            s_valid[0] = 1'b0;
        end
        expect_syms(0, "t5", 16, 32'h12345678, 16'hFFFE);
        $display("[TB] t5 four bytes held valid: %0d symbols", code_q.size());

        // 6: asynchronous reset mid-symbol, then a clean restart
        clear_q();
        send(0, 8'h3C);
        repeat (62) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_strobe", 32'(ppm_strobe[0]), 32'd0);
        check("t6_code", 32'(ppm_code[0]), 32'd0);
        check("t6_busy", 32'(busy[0]), 32'd0);
        check("t6_ready", 32'(s_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        send(0, 8'hA5);
        expect_syms(0, "t6", 4, 32'hA5, 16'b1110);
        $display("[TB] t6 restart after reset A5: %0d symbols", code_q.size());

        check("glitch0", 32'(g_dut[0].glitch_cnt), 32'd0);
        check("glitch1", 32'(g_dut[1].glitch_cnt), 32'd0);
        check("glitch2", 32'(g_dut[2].glitch_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
